// File: rtl/sata_phy_tx_prim_scheduler_if.sv
// Bundle between the link layer, the transceiver TX path and the primitive
// scheduler.
//   link_tx_data/link_tx_datak : dword and primitive flag from the link layer
//   link_tx_ready              : the dword is accepted on this cycle
//   phy_ready                  : transceiver TX is usable
//   phy_tx_data/phy_tx_datak   : registered dword and flag to the transceiver
//   stat_cont_active           : the scheduler is emitting CONT junk
// The master modport is the link/transceiver side. The slave modport is the
// scheduler.
interface sata_phy_tx_prim_scheduler_if;
  logic [31:0] link_tx_data;
  logic        link_tx_datak;
  logic        link_tx_ready;
  logic        phy_ready;
  logic [31:0] phy_tx_data;
  logic        phy_tx_datak;
  logic        stat_cont_active;

  modport master (
    output link_tx_data, link_tx_datak, phy_ready,
    input  link_tx_ready, phy_tx_data, phy_tx_datak, stat_cont_active
  );

  modport slave (
    input  link_tx_data, link_tx_datak, phy_ready,
    output link_tx_ready, phy_tx_data, phy_tx_datak, stat_cont_active
  );
endinterface

// File: rtl/sata_phy_tx_prim_scheduler.sv
// Transmit scheduler on the PHY side, placed between the link layer and the
// transceiver.
// - Inserts ALIGN_BURST ALIGN primitives every ALIGN_PERIOD cycles.
// - Forces ALIGN while phy_ready is low.
// - Applies CONT suppression to repeated primitives.
// - phy_tx_* outputs are registered, with 1-cycle latency.
// Ports:
//   clk, reset : clock, and an asynchronous active-high reset
//   bus        : slave modport of sata_phy_tx_prim_scheduler_if
module sata_phy_tx_prim_scheduler #(
  parameter int unsigned ALIGN_PERIOD = 256,
  parameter int unsigned ALIGN_BURST  = 2,
  parameter bit          CONT_ENA     = 1'b1
) (
  input logic                           clk,
  input logic                           reset,
  sata_phy_tx_prim_scheduler_if.slave   bus
);

  localparam logic [31:0] PrimAlign = 32'h7B4A4ABC;
  localparam logic [31:0] PrimCont  = 32'h9999AA7C;
  localparam logic [31:0] PrimSof   = 32'h3737B57C;
  localparam logic [31:0] PrimEof   = 32'hD5D5B57C;
  localparam logic [31:0] LfsrSeed  = 32'hC2D2768D;
  // Galois taps for x^32+x^22+x^2+x+1 (the x^32 term is the shifted-out bit).
  localparam logic [31:0] LfsrTaps  = 32'h00400007;
  localparam int unsigned CntW      = $clog2(ALIGN_PERIOD);

  typedef enum logic [1:0] {StIdle, StOne, StTwo, StJunk} cont_state_e;

  cont_state_e       state_q, state_d;
  logic [CntW-1:0]   slot_cnt_q, slot_cnt_d;
  logic [31:0]       last_prim_q, last_prim_d;
  logic [31:0]       lfsr_q, lfsr_d;
  logic [31:0]       tx_data_q, tx_data_d;
  logic              tx_datak_q, tx_datak_d;
  logic              align_slot;
  logic              eligible;
  logic [31:0]       lfsr_next;

  assign align_slot = slot_cnt_q < CntW'(ALIGN_BURST);

  assign eligible = bus.link_tx_datak &&
                    (bus.link_tx_data != PrimAlign) && (bus.link_tx_data != PrimCont) &&
                    (bus.link_tx_data != PrimSof)   && (bus.link_tx_data != PrimEof);

  assign lfsr_next = {lfsr_q[30:0], 1'b0} ^ (lfsr_q[31] ? LfsrTaps : 32'h0);

  always_comb begin
    slot_cnt_d  = '0;
    state_d     = state_q;
    last_prim_d = last_prim_q;
    lfsr_d      = lfsr_q;
    tx_data_d   = PrimAlign;
    tx_datak_d  = 1'b1;

    if (bus.phy_ready) begin
      slot_cnt_d = (slot_cnt_q == CntW'(ALIGN_PERIOD - 1)) ? '0 : slot_cnt_q + CntW'(1);
    end

    if (!bus.phy_ready) begin
      // The link is dead, so forget the repeat history. The LFSR keeps its state.
      state_d     = StIdle;
      last_prim_d = '0;
    end else if (!align_slot) begin
      // Dword accepted. During align slots all CONT state stays frozen.
      tx_data_d  = bus.link_tx_data;
      tx_datak_d = bus.link_tx_datak;
      if (!CONT_ENA || !eligible) begin
        state_d = StIdle;
      end else if ((state_q == StIdle) || (bus.link_tx_data != last_prim_q)) begin
        last_prim_d = bus.link_tx_data;
        state_d     = StOne;
      end else begin
        case (state_q)
          StOne: state_d = StTwo;
          StTwo: begin
            tx_data_d = PrimCont;
            state_d   = StJunk;
          end
          StJunk: begin
            tx_data_d  = lfsr_q;
            tx_datak_d = 1'b0;
            lfsr_d     = lfsr_next;
          end
          default: state_d = StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      slot_cnt_q  <= '0;
      last_prim_q <= '0;
      lfsr_q      <= LfsrSeed;
      tx_data_q   <= PrimAlign;
      tx_datak_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      slot_cnt_q  <= slot_cnt_d;
      last_prim_q <= last_prim_d;
      lfsr_q      <= lfsr_d;
      tx_data_q   <= tx_data_d;
      tx_datak_q  <= tx_datak_d;
    end
  end

  assign bus.link_tx_ready    = bus.phy_ready & ~align_slot;
  assign bus.phy_tx_data      = tx_data_q;
  assign bus.phy_tx_datak     = tx_datak_q;
  assign bus.stat_cont_active = (state_q == StJunk);

endmodule

// File: tb/tb_sata_phy_tx_prim_scheduler.sv
module tb_sata_phy_tx_prim_scheduler;

  localparam logic [31:0] ALIGN = 32'h7B4A4ABC;
  localparam logic [31:0] CONT  = 32'h9999AA7C;
  localparam logic [31:0] SYNC  = 32'hB5B5957C;
  localparam logic [31:0] HOLD  = 32'hD5D5AA7C;
  localparam logic [31:0] R_IP  = 32'h5555B57C;
  localparam logic [31:0] R_OK  = 32'h3535B57C;
  // First LFSR states, computed by hand from seed 0xC2D2768D.
  localparam logic [31:0] J0 = 32'hC2D2768D;
  localparam logic [31:0] J1 = 32'h85E4ED1D;
  localparam logic [31:0] J2 = 32'h0B89DA3D;
  localparam logic [31:0] J3 = 32'h1713B47A;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  sata_phy_tx_prim_scheduler_if u ();
  sata_phy_tx_prim_scheduler_if u2 ();

  sata_phy_tx_prim_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u)
  );

  sata_phy_tx_prim_scheduler #(
    .ALIGN_PERIOD (8),
    .ALIGN_BURST  (2),
    .CONT_ENA     (1'b0)
  ) dut_nocont (
    .clk   (clk),
    .reset (reset),
    .bus   (u2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Clock one edge, then check dut's output word and stat flag.
  task automatic step(input string tag, input logic [31:0] d, input logic k, input logic stat);
    tick();
    check(tag, {u.phy_tx_datak, u.phy_tx_data}, {k, d});
    check({tag, "_stat"}, 33'(u.stat_cont_active), 33'(stat));
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("rst_out", {u.phy_tx_datak, u.phy_tx_data}, {1'b1, ALIGN});
    check("rst_stat", 33'(u.stat_cont_active), 33'd0);
    check("rst_ready", 33'(u.link_tx_ready), 33'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rel_ready", 33'(u.link_tx_ready), 33'd0);
  endtask

  initial begin
    logic [31:0] word;
    logic        exp_rdy;
    logic [31:0] a_dat [8];
    logic        a_k   [8];

    u.phy_ready      = 1'b1;
    u.link_tx_data   = 32'h0;
    u.link_tx_datak  = 1'b0;
    u2.phy_ready     = 1'b1;
    u2.link_tx_data  = SYNC;
    u2.link_tx_datak = 1'b1;

    // A free-running data stream across several align periods.
    reset_dut();
    word = 32'h0;
    for (int e = 1; e <= 600; e++) begin
      exp_rdy = ((e - 1) % 256) >= 2;
      check("p_ready", 33'(u.link_tx_ready), 33'(exp_rdy));
      tick();
      if (exp_rdy) begin
        check("p_data", {u.phy_tx_datak, u.phy_tx_data}, {1'b0, word});
        word++;
      end else begin
        check("p_align", {u.phy_tx_datak, u.phy_tx_data}, {1'b1, ALIGN});
      end
      u.link_tx_data = word;
    end

    // A HOLD repeat that spans the ALIGN burst at slots 0 and 1.
    reset_dut();
    for (int e = 1; e <= 254; e++) begin
      u.link_tx_data = 32'(e);
      tick();
    end
    u.link_tx_data  = HOLD;
    u.link_tx_datak = 1'b1;
    step("b_hold1", HOLD, 1'b1, 1'b0);
    step("b_hold2", HOLD, 1'b1, 1'b0);
    step("b_align1", ALIGN, 1'b1, 1'b0);
    step("b_align2", ALIGN, 1'b1, 1'b0);
    step("b_cont", CONT, 1'b1, 1'b1);
    step("b_junk0", J0, 1'b0, 1'b1);
    step("b_junk1", J1, 1'b0, 1'b1);
    // Switching primitive while in JUNK; the LFSR continues where it was.
    u.link_tx_data = R_IP;
    step("c_rip1", R_IP, 1'b1, 1'b0);
    step("c_rip2", R_IP, 1'b1, 1'b0);
    step("c_rip_cont", CONT, 1'b1, 1'b1);
    step("c_junk2", J2, 1'b0, 1'b1);
    u.link_tx_data = R_OK;
    step("c_rok1", R_OK, 1'b1, 1'b0);
    step("c_rok2", R_OK, 1'b1, 1'b0);
    step("c_rok_cont", CONT, 1'b1, 1'b1);
    // A data dword arriving in JUNK passes through unchanged.
    u.link_tx_data  = 32'h12345678;
    u.link_tx_datak = 1'b0;
    step("c_data", 32'h12345678, 1'b0, 1'b0);

    // Drop phy_ready for 5 cycles in the middle of a SYNC repeat.
    u.link_tx_data  = SYNC;
    u.link_tx_datak = 1'b1;
    step("d_sync0", SYNC, 1'b1, 1'b0);
    u.phy_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("d_down_ready", 33'(u.link_tx_ready), 33'd0);
      step("d_down_align", ALIGN, 1'b1, 1'b0);
    end
    u.phy_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("d_up_ready", 33'(u.link_tx_ready), 33'd0);
      step("d_up_align", ALIGN, 1'b1, 1'b0);
    end
    check("d_resume_ready", 33'(u.link_tx_ready), 33'd1);
    step("d_sync1", SYNC, 1'b1, 1'b0);
    step("d_sync2", SYNC, 1'b1, 1'b0);
    step("d_cont", CONT, 1'b1, 1'b1);
    step("d_junk3", J3, 1'b0, 1'b1);

    // Reset asserted asynchronously in the middle of JUNK.
    #2;
    reset = 1'b1;
    #1;
    check("e_rst_out", {u.phy_tx_datak, u.phy_tx_data}, {1'b1, ALIGN});
    check("e_rst_stat", 33'(u.stat_cont_active), 33'd0);
    check("e_rst_ready", 33'(u.link_tx_ready), 33'd0);

    // Reset release with SYNC held. dut_nocont runs in parallel with CONT disabled.
    a_dat = '{ALIGN, ALIGN, SYNC, SYNC, CONT, J0, J1, J2};
    a_k   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (e <= 8) begin
        check("a_out", {u.phy_tx_datak, u.phy_tx_data}, {a_k[e-1], a_dat[e-1]});
        if (e != 5) check("a_stat", 33'(u.stat_cont_active), 33'(e >= 6));
      end
      check("f_out", {u2.phy_tx_datak, u2.phy_tx_data},
            {1'b1, (((e - 1) % 8) < 2) ? ALIGN : SYNC});
      check("f_stat", 33'(u2.stat_cont_active), 33'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sata_phy_tx_prim_scheduler.md
# sata_phy_tx_prim_scheduler

Physical-layer-side transmit scheduler between `sata_link_layer` (`phy_tx_data`/`phy_tx_datak`/`phy_tx_ready`) and the transceiver TX path.
- Inserts ALIGN bursts at a fixed period and throttles the link layer with `link_tx_ready` while doing so.
- Applies SATA CONT suppression to repeated primitives: two copies, then CONT, then scrambled junk until the primitive changes.
- Output is registered, 1-cycle latency.

## Interface
- ALIGN_PERIOD, 256: slot-counter period in cycles, range 4..65536.
- ALIGN_BURST, 2: ALIGN slots per period, range 1..ALIGN_PERIOD-2.
- CONT_ENA, 1: 1 enables CONT suppression; 0 passes primitives unchanged.
- reset  in  1  reset, asynchronous, active-high.
- clk  in  1  clock clk.
- link_tx_data  in  32  dword from the link layer.
- link_tx_datak  in  1  1 = dword is a primitive (`DWORD_IS_PRIM`).
- link_tx_ready  out  1  dword accepted this cycle; combinational from registered state and `phy_ready`.
- phy_ready  in  1  transceiver TX usable; low forces ALIGN output.
- phy_tx_data  out  32  registered dword to the transceiver.
- phy_tx_datak  out  1  registered primitive flag.
- stat_cont_active  out  1  registered; high while the FSM is in JUNK.

## Operation
- Primitive codes:
  - ALIGN 0x7B4A4ABC
  - CONT 0x9999AA7C
  - SOF 0x3737B57C
  - EOF 0xD5D5B57C
- Eligible primitive: `datak`=1 and data not in {ALIGN, CONT, SOF, EOF}.
- Slot counter `slot_cnt`:
  - Counts 0..ALIGN_PERIOD-1, then wraps to 0.
  - Increments every cycle while `phy_ready`=1.
  - Held at 0 while `phy_ready`=0.
  - Align slot = `slot_cnt` < ALIGN_BURST.
- `link_tx_ready` = `phy_ready` & ~align slot.
- Next output:
  - `phy_ready`=0 or align slot: ALIGN, datak=1.
  - Otherwise: per the CONT FSM below.
- CONT FSM states: IDLE, ONE, TWO, JUNK. Register `last_prim` holds 32 bits. Per accepted dword `d`:
  - `d` data or non-eligible primitive: output `d` unchanged; go to IDLE.
  - `d` eligible and (state IDLE or `d` != `last_prim`): output `d`; `last_prim` <= `d`; go to ONE.
  - `d` == `last_prim`, state ONE: output `d`; go to TWO.
  - `d` == `last_prim`, state TWO: output CONT, datak=1; go to JUNK.
  - `d` == `last_prim`, state JUNK: output LFSR word, datak=0; advance LFSR; stay in JUNK.
  - CONT_ENA=0: FSM is held in IDLE and every dword passes unchanged.
- FSM and LFSR in align slots:
  - FSM state, `last_prim` and LFSR are frozen during align slots.
  - A repeated primitive sequence may therefore span an ALIGN burst without restarting.
- FSM on `phy_ready`=0: FSM goes to IDLE, `last_prim` cleared to 0, LFSR is not reseeded.
- Junk LFSR:
  - 32-bit Galois, polynomial x^32+x^22+x^2+x+1, seed 0xC2D2768D.
  - Advances only when a junk dword is emitted.
  - The emitted word is the current state; the state advances after emission.

## Timing
- Reset values:
  - `phy_tx_data`=0x7B4A4ABC, `phy_tx_datak`=1, `stat_cont_active`=0.
  - `slot_cnt`=0, FSM IDLE, `last_prim`=0, LFSR=seed.
- `link_tx_ready`: low during reset and for the first ALIGN_BURST cycles with `phy_ready`=1 after reset.
- Latency: a dword accepted at edge N (`link_tx_ready`=1 in the preceding cycle) appears on `phy_tx_*` after edge N.
- The link layer must hold its dword while `link_tx_ready`=0; nothing is dropped or duplicated.
- Periodicity: with `phy_ready` constantly 1, `link_tx_ready` is low for exactly ALIGN_BURST of every ALIGN_PERIOD cycles.
- Deasserting `phy_ready` mid-period:
  - ALIGN appears on the next cycle.
  - On reassertion the period restarts at `slot_cnt`=0, i.e. an ALIGN burst comes first.
- Reset mid-sequence (including mid-JUNK): immediate return to all reset values.
- Changing primitive while in JUNK: the new primitive is output directly (no CONT); state goes to ONE.
- Data dword while in JUNK: passes unchanged; state goes to IDLE.

## Test plan
- Reset release, `phy_ready`=1, SYNC (0xB5B5957C) held on the link side:
  - Cycles 1-2 output ALIGN.
  - Then SYNC, SYNC, CONT.
  - Then junk words 0xC2D2768D followed by successive LFSR states, with datak=0 and `stat_cont_active`=1.
- ALIGN_PERIOD=256 with a free-running data stream 0,1,2,…:
  - `link_tx_ready` is low exactly at `slot_cnt` 0 and 1.
  - Output is gap-free and in order, with ALIGN×2 every 256 cycles.
- Repeated HOLD spanning an ALIGN burst:
  - Output is HOLD, HOLD, ALIGN, ALIGN, CONT, junk.
  - The FSM does not restart at the burst.
- In JUNK on R_IP, link switches to R_OK (0x3535B57C): next output is R_OK, then R_OK, then CONT.
- `phy_ready` dropped for 5 cycles mid-frame:
  - ALIGN output and `link_tx_ready`=0 for those 5 cycles.
  - After reassertion: 2 ALIGNs, then the held link dword, with no loss.
- CONT_ENA=0 with SYNC held: SYNC repeats forever; no CONT and no junk.
